transformation_block: RTL and testbench
=======================================

# transformation_block

Feature-transformation stage of the GCN accelerator: computes FM × WM, where FM is the node feature matrix (FEATURE_ROWS × FEATURE_COLS) and WM is the weight matrix (WEIGHT_ROWS × WEIGHT_COLS). It fetches one weight column and then every feature row through a shared external read port, and produces the FEATURE_ROWS × WEIGHT_COLS product matrix for the downstream aggregation stage.

## Interface
- FEATURE_COLS, 96: elements per feature row; must equal WEIGHT_ROWS.
- WEIGHT_ROWS, 96: elements per weight column; also the width of data_in in elements.
- FEATURE_ROWS, 6: number of nodes.
- WEIGHT_COLS, 3: number of output features.
- FEATURE_WIDTH, 5: unsigned feature element width.
- WEIGHT_WIDTH, 5: unsigned weight element width.
- DOT_PROD_WIDTH, 16: output element width.
- ADDRESS_WIDTH, 13: read address width.
- FEATURE_BASE_ADDR, 512: address of feature row 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  level request to run a full computation.
- data_in  in  WEIGHT_ROWS × WEIGHT_WIDTH (unpacked array)  memory read data. Combinational with respect to read_address.
- read_address  out  ADDRESS_WIDTH  address j reads weight column j; FEATURE_BASE_ADDR+i reads feature row i.
- enable_read  out  1  read_address is valid.
- fm_row_out  out  FEATURE_ROWS × WEIGHT_COLS × DOT_PROD_WIDTH (unpacked)  result matrix.
- done  out  1  all results valid.

## Operation
- FSM states: IDLE, READ_W, READ_F, DONE. Counters: col j in [0, WEIGHT_COLS-1], row i in [0, FEATURE_ROWS-1].
- IDLE: enable_read=0. If start=1 at an edge: j=0, i=0, go to READ_W.
- READ_W: enable_read=1, read_address=j. At the edge, latch data_in into the weight buffer (WEIGHT_ROWS elements), set i=0, and go to READ_F.
- READ_F: enable_read=1, read_address=FEATURE_BASE_ADDR+i.
  - Combinationally compute the sum over k of data_in[k]·wbuf[k]. Products are unsigned 10 bits. Accumulate at full width, then truncate to the low DOT_PROD_WIDTH bits (modulo 2^16).
  - At the edge, write the result to fm_row_out[i][j].
  - If i < FEATURE_ROWS-1: i++.
  - Else if j < WEIGHT_COLS-1: j++ and go to READ_W.
  - Else: go to DONE.
- DONE: done=1, enable_read=0. Stay in DONE while start=1. Return to IDLE when start=0. fm_row_out holds its value.
- read_address and enable_read are Moore decodes of state and counters. read_address is 0 whenever enable_read=0.
- Reset values: state IDLE, j=i=0, done=0, enable_read=0, read_address=0, weight buffer 0, all fm_row_out entries 0.
- Reset mid-run aborts immediately and returns every register to its reset value. Results are not preserved.
- start deasserted mid-run is ignored; the run completes.
- A new run overwrites fm_row_out entry by entry.

## Timing
- Read latency: data_in is sampled on the same edge that ends the cycle in which read_address was presented. There is zero wait states.
- Each weight column takes 1 + FEATURE_ROWS cycles. The full run takes WEIGHT_COLS·(1+FEATURE_ROWS) = 21 cycles after leaving IDLE.
- done rises after the 22nd rising edge that samples start=1, counting the IDLE→READ_W edge as the first.
- fm_row_out[i][j] is valid from the edge after its READ_F cycle. All entries are valid when done=1.

## Structure
- Shared package gcn_pkg holds the parameter defaults, FEATURE_BASE_ADDR, and the state enum typedef.
- One sub-module, dot_product_unit: combinational, WEIGHT_ROWS-wide multiply, adder tree, and truncation to DOT_PROD_WIDTH.
- The top holds the FSM, counters, weight buffer, and result registers.

## Test plan
- All features 1 and all weights 1 → every fm_row_out entry = 96. done high after 22 edges. Then deassert start → IDLE, done=0.
- Feature row i has only element 0 = i+1; weight column j has only element 0 = j+1 → fm_row_out[i][j] = (i+1)(j+1).
- All elements 31 → each entry = 92256 mod 65536 = 26720, which checks truncation.
- Monitor the address sequence → 0, 512..517, 1, 512..517, 2, 512..517. enable_read is high exactly during those 21 cycles.
- Assert reset at cycle 10 of a run → all outputs return to 0 asynchronously. A rerun then completes correctly.
- Zero weights with nonzero features → all entries 0, and done timing is unchanged.

Source files
------------

// File: rtl/gcn_pkg.sv
// Shared definitions for the GCN accelerator: default dimensions of the
// feature/weight matrices, the feature memory base address and FSM states.
package gcn_pkg;

   localparam int DEF_FEATURE_COLS      = 96;
   localparam int DEF_WEIGHT_ROWS       = 96;
   localparam int DEF_FEATURE_ROWS      = 6;
   localparam int DEF_WEIGHT_COLS       = 3;
   localparam int DEF_FEATURE_WIDTH     = 5;
   localparam int DEF_WEIGHT_WIDTH      = 5;
   localparam int DEF_DOT_PROD_WIDTH    = 16;
   localparam int DEF_ADDRESS_WIDTH     = 13;
   localparam int DEF_FEATURE_BASE_ADDR = 512;

   typedef enum logic [1:0] {
      IDLE,
      READ_W,
      READ_F,
      DONE
   } state_t;

endpackage

// File: rtl/dot_product_unit.sv
// Combinational dot product of one feature row with the buffered weight
// column; the sum is kept at full width and wrapped to the output width.
module dot_product_unit
   import gcn_pkg::*;
#(
   parameter int LENGTH    = DEF_FEATURE_COLS,
   parameter int A_WIDTH   = DEF_FEATURE_WIDTH,
   parameter int B_WIDTH   = DEF_WEIGHT_WIDTH,
   parameter int OUT_WIDTH = DEF_DOT_PROD_WIDTH
) (
   input  logic [A_WIDTH-1:0]   feature [LENGTH],
   input  logic [B_WIDTH-1:0]   weight  [LENGTH],
   output logic [OUT_WIDTH-1:0] result
);

   localparam int RAW_W = A_WIDTH + B_WIDTH + $clog2(LENGTH);
   localparam int ACC_W = (RAW_W > OUT_WIDTH) ? RAW_W : OUT_WIDTH;

   logic [ACC_W-1:0] acc;

   // Accumulator is wide enough that no partial sum overflows before the
   // final modulo-2^OUT_WIDTH truncation.
   always_comb begin
      acc = '0;
      for (int k = 0; k < LENGTH; k++) begin
         acc = acc + ACC_W'(feature[k]) * ACC_W'(weight[k]);
      end
   end

   assign result = OUT_WIDTH'(acc);

endmodule

// File: rtl/transformation_block.sv
// Feature-transformation stage: fetches one weight column, then every feature
// row, and stores each dot product into the FEATURE_ROWS x WEIGHT_COLS result.
module transformation_block
   import gcn_pkg::*;
#(
   parameter int FEATURE_COLS      = DEF_FEATURE_COLS,
   parameter int WEIGHT_ROWS       = DEF_WEIGHT_ROWS,
   parameter int FEATURE_ROWS      = DEF_FEATURE_ROWS,
   parameter int WEIGHT_COLS       = DEF_WEIGHT_COLS,
   parameter int FEATURE_WIDTH     = DEF_FEATURE_WIDTH,
   parameter int WEIGHT_WIDTH      = DEF_WEIGHT_WIDTH,
   parameter int DOT_PROD_WIDTH    = DEF_DOT_PROD_WIDTH,
   parameter int ADDRESS_WIDTH     = DEF_ADDRESS_WIDTH,
   parameter int FEATURE_BASE_ADDR = DEF_FEATURE_BASE_ADDR
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [WEIGHT_WIDTH-1:0]   data_in [WEIGHT_ROWS],
   output logic [ADDRESS_WIDTH-1:0]  read_address,
   output logic                      enable_read,
   output logic [DOT_PROD_WIDTH-1:0] fm_row_out [FEATURE_ROWS][WEIGHT_COLS],
   output logic                      done
);

   localparam int ROW_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
   localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_COLS - 1);
   localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(FEATURE_BASE_ADDR);

   state_t                    state;
   state_t                    next_state;
   logic [ROW_W-1:0]          row_idx;
   logic [COL_W-1:0]          col_idx;
   logic [WEIGHT_WIDTH-1:0]   weight_buf [WEIGHT_ROWS];
   logic [FEATURE_WIDTH-1:0]  feature_vec [FEATURE_COLS];
   logic [DOT_PROD_WIDTH-1:0] dot_result;

   // While in READ_F the read port carries a feature row; view it at feature width.
   always_comb begin
      for (int k = 0; k < FEATURE_COLS; k++) begin
         feature_vec[k] = FEATURE_WIDTH'(data_in[k]);
      end
   end

   dot_product_unit #(
      .LENGTH   (FEATURE_COLS),
      .A_WIDTH  (FEATURE_WIDTH),
      .B_WIDTH  (WEIGHT_WIDTH),
      .OUT_WIDTH(DOT_PROD_WIDTH)
   ) u_dot (
      .feature(feature_vec),
      .weight (weight_buf),
      .result (dot_result)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Outputs are pure Moore decodes; the address bus is parked at 0 when idle.
   always_comb begin
      next_state   = state;
      enable_read  = 1'b0;
      read_address = '0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            if (start) next_state = READ_W;
         end
         READ_W: begin
            enable_read  = 1'b1;
            read_address = ADDRESS_WIDTH'(col_idx);
            next_state   = READ_F;
         end
         READ_F: begin
            enable_read  = 1'b1;
            read_address = BASE_ADDR + ADDRESS_WIDTH'(row_idx);
            if (row_idx == LAST_ROW) begin
               next_state = (col_idx == LAST_COL) ? DONE : READ_W;
            end
         end
         DONE: begin
            done = 1'b1;
            if (!start) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_idx <= '0;
         col_idx <= '0;
         for (int k = 0; k < WEIGHT_ROWS; k++) weight_buf[k] <= '0;
         for (int r = 0; r < FEATURE_ROWS; r++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) fm_row_out[r][c] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  row_idx <= '0;
                  col_idx <= '0;
               end
            end
            READ_W: begin
               for (int k = 0; k < WEIGHT_ROWS; k++) weight_buf[k] <= data_in[k];
               row_idx <= '0;
            end
            READ_F: begin
               fm_row_out[row_idx][col_idx] <= dot_result;
               if (row_idx != LAST_ROW) begin
                  row_idx <= row_idx + 1'b1;
               end else if (col_idx != LAST_COL) begin
                  col_idx <= col_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_transformation_block.sv
// Directed bench for transformation_block: a behavioural memory answers the
// read port and each step compares outputs against hand-computed values.
module tb_transformation_block;
   import gcn_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  data_in [96];
   logic [12:0] read_address;
   logic        enable_read;
   logic [15:0] fm_row_out [6][3];
   logic        done;

   logic [4:0]  wmem [3][96];
   logic [4:0]  fmem [6][96];

   int checks = 0;
   int errors = 0;

   transformation_block dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .data_in     (data_in),
      .read_address(read_address),
      .enable_read (enable_read),
      .fm_row_out  (fm_row_out),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Zero-wait-state memory: weight columns at 0..2, feature rows at 512..517.
   always_comb begin
      for (int k = 0; k < 96; k++) data_in[k] = '0;
      if (read_address < 13'd3) begin
         for (int k = 0; k < 96; k++) data_in[k] = wmem[read_address[1:0]][k];
      end else if (read_address >= 13'd512 && read_address < 13'd518) begin
         for (int k = 0; k < 96; k++) data_in[k] = fmem[3'(read_address - 13'd512)][k];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic fill_mem(input logic [4:0] fval, input logic [4:0] wval);
      for (int k = 0; k < 96; k++) begin
         for (int j = 0; j < 3; j++) wmem[j][k] = wval;
         for (int i = 0; i < 6; i++) fmem[i][k] = fval;
      end
   endtask

   task automatic check_all_results(input string tag, input int value);
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 3; j++) begin
            check_output($sformatf("%s[%0d][%0d]", tag, i, j), 32'(fm_row_out[i][j]), value);
         end
      end
   endtask

   // Runs a full computation, checking the read sequence and done timing each cycle.
   task automatic apply_stimulus();
      int idx, pos, exp_addr;
      start = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         tick();
         if (e <= 21) begin
            idx      = e - 1;
            pos      = idx % 7;
            exp_addr = (pos == 0) ? idx / 7 : 512 + pos - 1;
            check_output($sformatf("done_low_e%0d", e), 32'(done), 0);
            check_output($sformatf("enable_e%0d", e), 32'(enable_read), 1);
            check_output($sformatf("addr_e%0d", e), 32'(read_address), exp_addr);
         end else begin
            check_output("done_high", 32'(done), 1);
            check_output("enable_done", 32'(enable_read), 0);
            check_output("addr_done", 32'(read_address), 0);
         end
      end
   endtask

   task automatic release_start();
      start = 1'b0;
      tick();
      check_output("done_after_release", 32'(done), 0);
      check_output("enable_after_release", 32'(enable_read), 0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      fill_mem(5'd0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_done", 32'(done), 0);
      check_output("reset_enable", 32'(enable_read), 0);
      check_output("reset_addr", 32'(read_address), 0);
      check_all_results("reset_fm", 0);
      reset = 1'b0;
      tick();
      check_output("idle_enable", 32'(enable_read), 0);

      $display("[TB] all-ones run");
      fill_mem(5'd1, 5'd1);
      apply_stimulus();
      check_all_results("ones", 96);
      release_start();

      $display("[TB] single-element run aborted by reset");
      fill_mem(5'd0, 5'd0);
      for (int j = 0; j < 3; j++) wmem[j][0] = 5'(j + 1);
      for (int i = 0; i < 6; i++) fmem[i][0] = 5'(i + 1);
      start = 1'b1;
      repeat (10) tick();
      reset = 1'b1;
      start = 1'b0;
      #1;
      check_output("abort_done", 32'(done), 0);
      check_output("abort_enable", 32'(enable_read), 0);
      check_output("abort_addr", 32'(read_address), 0);
      check_all_results("abort_fm", 0);
      tick();
      reset = 1'b0;
      tick();

      $display("[TB] single-element rerun");
      apply_stimulus();
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 3; j++) begin
            check_output($sformatf("diag[%0d][%0d]", i, j), 32'(fm_row_out[i][j]), (i + 1) * (j + 1));
         end
      end
      release_start();

      $display("[TB] saturation run");
      fill_mem(5'd31, 5'd31);
      apply_stimulus();
      check_all_results("max", 26720);
      release_start();

      $display("[TB] zero-weight run");
      fill_mem(5'd17, 5'd0);
      apply_stimulus();
      check_all_results("zero_w", 0);
      release_start();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
